// File: rtl/video_timing_pkg.sv
// Shared 640x480 horizontal timing constants and the horizontal state type.
// The timing generator and the Hsync decoder both import this package.
package video_timing_pkg;

    // Nominal 640x480 horizontal timing, in pixel clocks
    localparam int HSYNC_CLKS        = 800;
    localparam int HSYNC_DISPLAY     = 640;
    localparam int HSYNC_PULSE       = 96;
    localparam int HSYNC_FRONT_PORCH = 16;
    localparam int HSYNC_BACK_PORCH  = 48;

    // Horizontal counter width; must hold the timeout count (816)
    localparam int HCNT_W = 10;
    typedef logic [HCNT_W-1:0] hcnt_t;

    // Counter values at which the line changes phase
    localparam hcnt_t H_PULSE_END  = hcnt_t'(HSYNC_PULSE);
    localparam hcnt_t H_DISP_START = hcnt_t'(HSYNC_PULSE + HSYNC_BACK_PORCH);
    localparam hcnt_t H_DISP_END   = hcnt_t'(HSYNC_PULSE + HSYNC_BACK_PORCH + HSYNC_DISPLAY);
    localparam hcnt_t H_LINE       = hcnt_t'(HSYNC_CLKS);
    localparam hcnt_t H_TIMEOUT    = hcnt_t'(HSYNC_CLKS + HSYNC_FRONT_PORCH);

    // Phase of the line currently being received
    typedef enum logic [2:0] {
        SEARCH,
        PULSE,
        BACK_PORCH,
        DISPLAY,
        FRONT_PORCH
    } hstate_t;

endpackage

// File: rtl/hsync_timing_decoder_if.sv
// Bundle between the Hsync source pins and the decoder outputs.
// master: the video source / consumer side; slave: the decoder.
interface hsync_timing_decoder_if;
    import video_timing_pkg::*;

    logic  hsync;       // incoming Hsync, active low, asynchronous to clk
    logic  h_display;   // active pixel of a locked line
    hcnt_t h_pixel;     // pixel column, 0 outside display
    logic  line_start;  // one-cycle pulse per Hsync fall while locked
    logic  locked;      // lock status
    logic  err;         // one-cycle pulse per timing violation
    hcnt_t line_len;    // last measured fall-to-fall period

    modport master (
        output hsync,
        input  h_display, h_pixel, line_start, locked, err, line_len
    );

    modport slave (
        input  hsync,
        output h_display, h_pixel, line_start, locked, err, line_len
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a delay flop, giving
// single-cycle rise and fall pulses. Shared by the H and V sync decoders.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronize din and keep one extra sample for edge detection; the
    // chain resets to the idle-high level so reset never creates an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true shift chain;
            // blocking ones would collapse the three flops into one.
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = ~s2 &  s3;
    assign rise =  s2 & ~s3;

endmodule

// File: rtl/hsync_timing_decoder.sv
// Receive-side horizontal timing recovery. Measures the incoming Hsync
// against nominal 640x480 timing, locks after LOCK_LINES good lines in a
// row, and regenerates display-enable and pixel column for capture logic.
module hsync_timing_decoder
    import video_timing_pkg::*;
#(
    parameter int LOCK_LINES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hsync_timing_decoder_if.slave  bus
);

    localparam int GL_W = $clog2(LOCK_LINES + 1);
    typedef logic [GL_W-1:0] glines_t;
    localparam glines_t LOCK_MAX = glines_t'(LOCK_LINES);

    logic    hs_rise;
    logic    hs_fall;

    hstate_t state;
    hstate_t state_next;
    hcnt_t   cnt;
    hcnt_t   cnt_inc;
    hcnt_t   cnt_next;
    glines_t good_lines;
    glines_t good_next;
    logic    pulse_ok;
    logic    pulse_ok_next;
    hcnt_t   line_len;
    hcnt_t   line_len_next;
    logic    err_evt;
    logic    err_next;
    logic    start_evt;
    logic    start_next;
    logic    locked_now;

    sync_edge_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.hsync),
        .rise  (hs_rise),
        .fall  (hs_fall)
    );

    // Line state, counter, good-line tally and per-cycle event flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            cnt        <= '0;
            good_lines <= '0;
            pulse_ok   <= 1'b0;
            line_len   <= '0;
            err_evt    <= 1'b0;
            start_evt  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            good_lines <= good_next;
            pulse_ok   <= pulse_ok_next;
            line_len   <= line_len_next;
            err_evt    <= err_next;
            start_evt  <= start_next;
        end
    end

    // Next-state decode. All width/period checks compare against cnt+1, the
    // value the counter reaches at this edge, so an edge N clocks after the
    // line's fall reads as exactly N.
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise
        // any path that skips an assignment infers a latch.
        cnt_inc       = cnt + 1'b1;
        state_next    = state;
        cnt_next      = cnt_inc;
        good_next     = good_lines;
        pulse_ok_next = pulse_ok;
        line_len_next = line_len;
        err_next      = 1'b0;

        if (state == SEARCH) begin
            cnt_next = '0;
            if (hs_fall) begin
                state_next    = PULSE;
                pulse_ok_next = 1'b0;
            end
        end else if (hs_fall) begin
            // A fall always starts a new line, early, late or on time; it
            // also wins over a timeout landing in the same cycle
            state_next    = PULSE;
            cnt_next      = '0;
            pulse_ok_next = 1'b0;
            line_len_next = cnt_inc;
            if (cnt_inc != H_LINE) begin
                err_next  = 1'b1;
                good_next = '0;
            end else if (pulse_ok && (good_lines != LOCK_MAX)) begin
                good_next = good_lines + 1'b1;
            end
        end else if (cnt_inc == H_TIMEOUT) begin
            // Sync lost altogether: drop back to hunting, keep last length
            state_next = SEARCH;
            cnt_next   = '0;
            err_next   = 1'b1;
            good_next  = '0;
        end else begin
            case (state)
                PULSE: begin
                    if (hs_rise) begin
                        state_next = BACK_PORCH;
                        if (cnt_inc == H_PULSE_END) begin
                            pulse_ok_next = 1'b1;
                        end else begin
                            err_next  = 1'b1;
                            good_next = '0;
                        end
                    end
                end
                BACK_PORCH: begin
                    if (cnt_inc == H_DISP_START) state_next = DISPLAY;
                end
                DISPLAY: begin
                    if (cnt_inc == H_DISP_END) state_next = FRONT_PORCH;
                end
                default: begin
                    state_next = state;
                end
            endcase
        end

        // Line start is flagged with the lock status that results from this fall
        start_next = hs_fall && (good_next == LOCK_MAX);
    end

    assign locked_now = (good_lines == LOCK_MAX);

    // Registered outputs, one cycle behind the line state and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.h_display  <= 1'b0;
            bus.h_pixel    <= '0;
            bus.line_start <= 1'b0;
            bus.locked     <= 1'b0;
            bus.err        <= 1'b0;
            bus.line_len   <= '0;
        end else begin
            bus.h_display  <= locked_now && (state == DISPLAY);
            bus.h_pixel    <= (state == DISPLAY) ? (cnt - H_DISP_START) : '0;
            bus.line_start <= start_evt;
            bus.locked     <= locked_now;
            bus.err        <= err_evt;
            bus.line_len   <= line_len;
        end
    end

endmodule

// File: tb/tb_hsync_timing_decoder.sv
// Testbench for hsync_timing_decoder. A pin waveform is built as a list of
// lines (pulse width, period); a line-level model turns the list of Hsync
// falls into expected outputs per clock edge, and every edge is compared.
module tb_hsync_timing_decoder;
    import video_timing_pkg::*;

    localparam int MAX_T     = 50000;
    localparam int LOCK_N    = 4;
    localparam int T_PULSE   = HSYNC_PULSE;
    localparam int T_LINE    = HSYNC_CLKS;
    localparam int T_DSTART  = HSYNC_PULSE + HSYNC_BACK_PORCH;
    localparam int T_TIMEOUT = HSYNC_CLKS + HSYNC_FRONT_PORCH;
    localparam int SYNC_LAT  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hsync_timing_decoder_if bus ();

    hsync_timing_decoder #(.LOCK_LINES(LOCK_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Pin level sampled at each clock edge after reset release
    bit pin [MAX_T];
    int n_edges = 0;

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            pin[n_edges] = 1'b1;
            n_edges++;
        end
    endtask

    task automatic add_line(input int width, input int period);
        for (int i = 0; i < period; i++) begin
            pin[n_edges] = (i >= width);
            n_edges++;
        end
    endtask

    // Model state "after edge t"
    bit ev_err   [MAX_T];
    bit ev_start [MAX_T];
    int good_set [MAX_T];
    int len_set  [MAX_T];
    int pix      [MAX_T];
    int g_after  [MAX_T];
    int l_after  [MAX_T];

    // Walk the detected falls line by line and mark the edges where errors,
    // line starts, lock count, measured length and display pixels occur
    task automatic build_model();
        int falls[$];
        int widths[$];
        int cur, cur_w, good, d, w, p, line_end, r, g_run, l_run;
        for (int t = 0; t < MAX_T; t++) begin
            ev_err[t]   = 1'b0;
            ev_start[t] = 1'b0;
            good_set[t] = -1;
            len_set[t]  = -1;
            pix[t]      = -1;
        end
        for (int t = 0; t < n_edges; t++) begin
            if (pin[t] == 1'b0 && (t == 0 || pin[t-1] == 1'b1)) begin
                r = t;
                while (r < n_edges && pin[r] == 1'b0) r++;
                falls.push_back(t + SYNC_LAT);
                widths.push_back(r - t);
            end
        end
        cur = -1;
        cur_w = 0;
        good = 0;
        foreach (falls[i]) begin
            d = falls[i];
            w = widths[i];
            if (cur >= 0 && d - cur > T_TIMEOUT) begin
                ev_err[cur + T_TIMEOUT] = 1'b1;
                good = 0;
                good_set[cur + T_TIMEOUT] = 0;
                cur = -1;
            end
            if (cur >= 0) begin
                p = d - cur;
                len_set[d] = p;
                if (p != T_LINE) begin
                    ev_err[d] = 1'b1;
                    good = 0;
                end else if (cur_w == T_PULSE && good < LOCK_N) begin
                    good++;
                end
            end
            good_set[d] = good;
            ev_start[d] = (good == LOCK_N);
            line_end = (i + 1 < falls.size()) ? falls[i+1] : MAX_T;
            if (d + T_TIMEOUT < line_end) line_end = d + T_TIMEOUT;
            if (w != T_PULSE && d + w < line_end) begin
                ev_err[d + w] = 1'b1;
                good = 0;
                good_set[d + w] = 0;
            end
            for (int j = 0; j < HSYNC_DISPLAY; j++) begin
                if (d + T_DSTART + j < line_end) pix[d + T_DSTART + j] = j;
            end
            cur = d;
            cur_w = w;
        end
        if (cur >= 0 && cur + T_TIMEOUT < MAX_T) begin
            ev_err[cur + T_TIMEOUT] = 1'b1;
            good_set[cur + T_TIMEOUT] = 0;
        end
        g_run = 0;
        l_run = 0;
        for (int t = 0; t < MAX_T; t++) begin
            if (good_set[t] >= 0) g_run = good_set[t];
            if (len_set[t] >= 0) l_run = len_set[t];
            g_after[t] = g_run;
            l_after[t] = l_run;
        end
    endtask

    // Expected outputs after edge e, packed as
    // {h_display, h_pixel[9:0], line_start, locked, err, line_len[9:0]}
    function automatic logic [31:0] expected_at(input int e);
        int   s;
        logic lk;
        logic dsp;
        int   px;
        if (e == 0) return '0;
        s   = e - 1;
        lk  = (g_after[s] == LOCK_N);
        dsp = (pix[s] >= 0) && lk;
        px  = (pix[s] >= 0) ? pix[s] : 0;
        return {8'd0, dsp, 10'(px), ev_start[s], lk, ev_err[s], 10'(l_after[s])};
    endfunction

    function automatic logic [31:0] observed();
        return {8'd0, bus.h_display, bus.h_pixel, bus.line_start, bus.locked, bus.err, bus.line_len};
    endfunction

    initial begin
        int f_last;
        int d_last;
        int run_len;
        int p;
        int w;

        bus.hsync = 1'b1;

        add_idle(20);
        repeat (6) add_line(96, 800);   // lock on the 5th fall, 6th line displayed
        add_line(95, 800);              // short pulse
        repeat (5) add_line(96, 800);   // relock
        add_line(96, 799);              // early fall
        repeat (5) add_line(96, 800);
        add_line(96, 816);              // fall coincides with the timeout cycle
        repeat (5) add_line(96, 800);
        add_line(96, 817);              // timeout one cycle before the fall
        repeat (5) add_line(96, 800);
        repeat (12) begin
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(790, 817)) : 800;
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(93, 99)) : 96;
            add_line(w, p);
        end
        repeat (5) add_line(96, 800);
        add_line(96, 1000);             // Hsync stuck high after this fall
        repeat (5) add_line(96, 800);
        f_last = n_edges;
        add_line(96, 800);
        add_idle(10);

        build_model();
        d_last  = f_last + SYNC_LAT;
        run_len = d_last + T_DSTART + 300 + 2;

        repeat (3) @(negedge clk);
        check("rst_display", bus.h_display, 0);
        check("rst_pixel", bus.h_pixel, 0);
        check("rst_line_start", bus.line_start, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_err", bus.err, 0);
        check("rst_line_len", bus.line_len, 0);

        rst_n = 1'b1;
        for (int e = 0; e < run_len; e++) begin
            bus.hsync = pin[e];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("outs@%0d", e), observed(), expected_at(e));
        end

        // Mid-display of a locked line at pixel 300: reset without a clock edge
        check("pre_rst_pixel", bus.h_pixel, 300);
        check("pre_rst_locked", bus.locked, 1);
        check("pre_rst_display", bus.h_display, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_display", bus.h_display, 0);
        check("async_pixel", bus.h_pixel, 0);
        check("async_locked", bus.locked, 0);
        check("async_line_len", bus.line_len, 0);

        bus.hsync = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_locked", bus.locked, 0);
        check("post_rst_display", bus.h_display, 0);
        check("post_rst_err", bus.err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
